// File: rtl/gw_pkg.sv
// Shared types and lane arithmetic for the gradient-weight kernels.
`default_nettype none

package gw_pkg;

  localparam int LANE_BITS = 16;
  localparam int WORD_BITS = 2 * LANE_BITS;

  typedef logic [LANE_BITS-1:0] lane_t;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  function automatic lane_t lane_gx(input word_t w);
    return w[LANE_BITS-1:0];
  endfunction

  function automatic lane_t lane_gy(input word_t w);
    return w[WORD_BITS-1:LANE_BITS];
  endfunction

  function automatic word_t pack_word(input lane_t gy, input lane_t gx);
    return {gy, gx};
  endfunction

  // [1,2,1]/4 with floor; the 18-bit sum cannot overflow, so bits [17:2] are exact.
  function automatic lane_t weight121(input lane_t t, input lane_t c, input lane_t b);
    logic [LANE_BITS+1:0] s;
    s = {{2{t[LANE_BITS-1]}}, t}
      + {c[LANE_BITS-1], c, 1'b0}
      + {{2{b[LANE_BITS-1]}}, b};
    return s[LANE_BITS+1:2];
  endfunction

  function automatic word_t weight_word(input word_t t, input word_t c, input word_t b);
    return pack_word(weight121(lane_gy(t), lane_gy(c), lane_gy(b)),
                     weight121(lane_gx(t), lane_gx(c), lane_gx(b)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/gw_line_buffer.sv
// Two-row line store: shift-write (row0 <= row1, row1 <= in) at one column, async read.
`default_nettype none

module gw_line_buffer #(
  parameter int WIDTH     = 64,
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 we_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] row0_o,
  output logic [WORD_BITS-1:0] row1_o
);

  logic [WORD_BITS-1:0] lb0_q [WIDTH];
  logic [WORD_BITS-1:0] lb1_q [WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lb0_q[addr_i] <= lb1_q[addr_i];
      lb1_q[addr_i] <= wdata_i;
    end
  end

  assign row0_o = lb0_q[addr_i];
  assign row1_o = lb1_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/gradient_weight_y1.sv
// Vertical [1,2,1]/4 smoothing of packed {gy,gx} gradient words, one row delayed.
// LANE_BITS must match gw_pkg::LANE_BITS (the lane arithmetic is package-defined).
`default_nettype none

module gradient_weight_y1 #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int LANE_BITS = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [2*LANE_BITS-1:0] Input_1_V_V,
  input  logic                   Input_1_V_V_ap_vld,
  output logic                   Input_1_V_V_ap_ack,
  output logic [2*LANE_BITS-1:0] Output_1_V_V,
  output logic                   Output_1_V_V_ap_vld,
  input  logic                   Output_1_V_V_ap_ack,
  output logic                   ap_idle
);

  import gw_pkg::*;

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  word_t              out_q, out_d;
  logic               out_vld_q, out_vld_d;

  logic               slot_free;
  logic               in_ack;
  logic               in_acc;
  word_t              lb_row0, lb_row1;

  assign slot_free = !out_vld_q || Output_1_V_V_ap_ack;
  assign in_acc    = Input_1_V_V_ap_vld && in_ack;

  gw_line_buffer #(
    .WIDTH     (WIDTH),
    .WORD_BITS (2 * LANE_BITS),
    .ADDR_BITS (COL_W)
  ) u_lb (
    .clk_i   (ap_clk),
    .addr_i  (col_q),
    .we_i    (in_acc),
    .wdata_i (Input_1_V_V),
    .row0_o  (lb_row0),
    .row1_o  (lb_row1)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= FILL;
      row_q     <= '0;
      col_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    out_d     = out_q;
    out_vld_d = out_vld_q && !Output_1_V_V_ap_ack;
    case (state_q)
      FILL: begin
        if (in_acc) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = ROW_ONE;
            state_d = STREAM;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (in_acc) begin
          // Output row 0 has no row above it.
          out_d     = weight_word((row_q == ROW_ONE) ? '0 : lb_row0, lb_row1, Input_1_V_V);
          out_vld_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_d     = weight_word((HEIGHT == 2) ? '0 : lb_row0, lb_row1, '0);
          out_vld_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = '0;
            state_d = FILL;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ack = 1'b0;
    if (ap_rst_n) begin
      case (state_q)
        FILL:    in_ack = 1'b1;
        STREAM:  in_ack = slot_free;
        default: in_ack = 1'b0;
      endcase
    end
  end

  assign Input_1_V_V_ap_ack  = in_ack;
  assign Output_1_V_V        = out_q;
  assign Output_1_V_V_ap_vld = out_vld_q;
  assign ap_idle             = (state_q == FILL) && (row_q == '0) && (col_q == '0) && !out_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_gradient_weight_y1.sv
// Directed bench for gradient_weight_y1 at WIDTH=4, HEIGHT=3.
`default_nettype none

module tb_gradient_weight_y1;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_vld = 1'b0;
  logic        in_ack;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack = 1'b0;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;
  int stalls;
  int first_vld_k;

  logic [31:0] words [2*N];
  logic [31:0] got [$];

  always #5 clk = ~clk;

  gradient_weight_y1 #(.WIDTH(W), .HEIGHT(H), .LANE_BITS(16)) dut (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .Input_1_V_V         (in_data),
    .Input_1_V_V_ap_vld  (in_vld),
    .Input_1_V_V_ap_ack  (in_ack),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack),
    .ap_idle             (idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [31:0] w, input bit hi);
    logic signed [15:0] v;
    v = hi ? w[31:16] : w[15:0];
    return int'(v);
  endfunction

  // Reference: frame starts at words[base]; rows outside the frame read as zero.
  function automatic logic [15:0] ref_lane(input int base, input int r, input int c, input bit hi);
    int t, m, b, s;
    m = lane(words[base + r*W + c], hi);
    t = (r > 0)     ? lane(words[base + (r-1)*W + c], hi) : 0;
    b = (r < H - 1) ? lane(words[base + (r+1)*W + c], hi) : 0;
    s = t + 2*m + b;
    return 16'(s >>> 2);
  endfunction

  function automatic logic [31:0] ref_word(input int base, input int idx);
    return {ref_lane(base, idx / W, idx % W, 1'b1), ref_lane(base, idx / W, idx % W, 1'b0)};
  endfunction

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 2*N; i++) words[i] = v;
  endtask

  task automatic fill_ramp();
    int gx;
    for (int i = 0; i < 2*N; i++) begin
      gx = 100 * ((i % N) / W) + (i % W);
      words[i] = {16'(-gx), 16'(gx)};
    end
  endtask

  // Stream n_in words in; collect every accepted output. toggle acks output 1 cycle in 3.
  task automatic run(input int n_in, input bit toggle);
    int k = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] held = '0;
    got.delete();
    stalls = 0;
    first_vld_k = -1;
    while ((k < n_in || got.size() < n_in) && cyc < 400) begin
      @(negedge clk);
      out_ack = toggle ? (cyc % 3 == 0) : 1'b1;
      in_vld  = (k < n_in);
      in_data = (k < n_in) ? words[k] : '0;
      #1;
      if (hold) begin
        check("hold_vld", 32'(out_vld), 32'd1);
        check("hold_data", out_data, held);
      end
      if (out_vld && !out_ack && in_vld && k >= W) check("in_stall", 32'(in_ack), 32'd0);
      if (out_vld && first_vld_k < 0) first_vld_k = k;
      if (in_vld && !in_ack) stalls++;
      if (out_vld && out_ack) got.push_back(out_data);
      if (in_vld && in_ack) k++;
      hold = out_vld && !out_ack;
      held = out_data;
      @(posedge clk);
      cyc++;
    end
    in_vld = 1'b0;
    check("run_inputs", k, n_in);
    check("run_outputs", got.size(), n_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ack", 32'(in_ack), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_after_rst", 32'(idle), 32'd1);
    check("fill_in_ack", 32'(in_ack), 32'd1);

    // Constant {4,4}
    fill_const(32'h0004_0004);
    run(N, 1'b0);
    check("first_vld_after_input5", first_vld_k, 5);
    for (int i = 0; i < N; i++) begin
      e = (i >= W && i < 2*W) ? 32'h0004_0004 : 32'h0003_0003;
      check("const_p4", got[i], e);
    end

    // Constant {-4,-4}
    fill_const(32'hFFFC_FFFC);
    run(N, 1'b0);
    for (int i = 0; i < N; i++) begin
      e = (i >= W && i < 2*W) ? 32'hFFFC_FFFC : 32'hFFFD_FFFD;
      check("const_m4", got[i], e);
    end

    // Constant {1,1}: edges floor to 0
    fill_const(32'h0001_0001);
    run(N, 1'b0);
    for (int i = 0; i < N; i++) begin
      e = (i >= W && i < 2*W) ? 32'h0001_0001 : 32'h0000_0000;
      check("const_p1", got[i], e);
    end

    // Ramp gx = 100*row + col, gy = -gx
    fill_ramp();
    run(N, 1'b0);
    check("ramp_r0c0", got[0],  32'hFFE7_0019);
    check("ramp_r0c3", got[3],  32'hFFE4_001B);
    check("ramp_r1c2", got[6],  32'hFF9A_0066);
    check("ramp_r2c0", got[8],  32'hFF83_007D);
    check("ramp_r2c3", got[11], 32'hFF80_007F);
    for (int i = 0; i < N; i++) check("ramp_model", got[i], ref_word(0, i));

    // Output backpressure
    run(N, 1'b1);
    for (int i = 0; i < N; i++) check("ramp_bp", got[i], ref_word(0, i));

    // Two back-to-back frames, input always offered
    run(2*N, 1'b0);
    check("flush_stall_cycles", stalls, W);
    for (int i = 0; i < 2*N; i++) check("b2b", got[i], ref_word((i / N) * N, i % N));

    // Reset pulse partway through row 1
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      out_ack = 1'b1;
      in_vld  = 1'b1;
      in_data = words[i];
    end
    @(negedge clk);
    in_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("in_ack_during_rst", 32'(in_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("vld_after_pulse", 32'(out_vld), 32'd0);
    check("idle_after_pulse", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("idle_before_input", 32'(idle), 32'd1);
    run(N, 1'b0);
    for (int i = 0; i < N; i++) check("after_rst", got[i], ref_word(0, i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
